card_match_ctrl: RTL and testbench
==================================

Name: card_match_ctrl

Overview:
- Game sequencer for the 4x4 memory-card board: owns cursor position, face-up mask and pair-matching logic.
- Drives the per-card enable inputs of the 16 card renderers; grid index 0..15 is row-major, row = idx[3:2], col = idx[1:0].
- Takes one-cycle button pulses from the debouncer and a face-value layout from the shuffle logic.
- Reveals two cards, compares them, then keeps a matched pair up or hides a mismatch after a timed delay.

Parameters:
- MISMATCH_CYCLES, 25_000_000, cycles both mismatched cards stay visible (0.5 s at 50 MHz); must be >= 1.
- FACE_W, 3, bits per face value (8 pairs).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: new game, loads layout
- layout  in  16*FACE_W  face value of card i at bits [i*FACE_W +: FACE_W]; sampled only on start
- btn_up, btn_down, btn_left, btn_right  in  1 each  one-cycle cursor move pulses
- btn_sel  in  1  one-cycle select pulse
- face_up  out  16  bit i = card i shown face-up (feeds the renderer enable)
- cursor  out  4  highlighted card index
- pairs_found  out  4  matched pairs, 0..8
- game_won  out  1  high once all 8 pairs are matched
- busy  out  1  high in COMPARE and SHOW_MISS (input ignored)

Behaviour:
- Reset: face_up=0, cursor=0, pairs_found=0, game_won=0, busy=0, state=IDLE, matched mask=0, layout regs=0.
- States: IDLE, PICK1, PICK2, COMPARE, SHOW_MISS, WON.
- IDLE: waits for start. start in any state latches layout, clears face_up, matched mask and pairs_found, sets cursor=0 and goes to PICK1 on the next edge. start has priority over every other input in the same cycle.
- Cursor moves only in PICK1/PICK2. No wrap-around; moves at an edge are ignored:
  - up: row>0, cursor-4
  - down: row<3, cursor+4
  - left: col>0, cursor-1
  - right: col<3, cursor+1
- Simultaneous move pulses in one cycle: priority up>down>left>right, only one applied.
- btn_sel in PICK1:
  - cursor card already face-up: ignored.
  - otherwise: set face_up[cursor], store first=cursor, go to PICK2.
- btn_sel in PICK2:
  - cursor card face-up (including first): ignored.
  - otherwise: set face_up[cursor], store second=cursor, go to COMPARE.
- A move and btn_sel in the same cycle: the selection uses the pre-move cursor, and the move is also applied.
- COMPARE (exactly one cycle, busy=1):
  - Faces equal: set matched[first], matched[second], pairs_found+1. Go to WON if the new count is 8, else PICK1.
  - Faces differ: load timer=MISMATCH_CYCLES-1 and go to SHOW_MISS.
- SHOW_MISS: decrement timer each cycle. At timer==0, clear face_up[first] and face_up[second] and go to PICK1. Visible duration is exactly MISMATCH_CYCLES cycles after COMPARE.
- WON: game_won=1 and face_up stays all ones; only start leaves this state.
- Invariant: face_up = matched | pending picks; matched bits never clear except on start or reset.
- Reset mid-operation: asynchronous, clears everything immediately with no partial reveal. All outputs are registered.
- busy is high exactly in COMPARE and SHOW_MISS. Button pulses during busy are dropped, not queued.

Optional Feature:
- CARD_MATCH_ATTEMPTS_EN
- Defined: adds output attempts[7:0]. It clears on reset and on start, increments by 1 in every COMPARE cycle, and saturates at 255.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Package card_match_pkg: state enum, GRID_DIM=4, NUM_CARDS=16, NUM_PAIRS=8, FACE_W default, helper functions idx_row/idx_col.
- One sub-module, card_cursor_nav: combinational next-cursor from the current cursor and the four move pulses, with edge clamping and priority. Everything else stays in card_match_ctrl.

Test Plan:
- Reset/start: rst_n low mid-game -> all outputs 0. Then start with layout {0,0,1,1,...,7,7} -> PICK1, cursor=0, face_up=0.
- Navigation: from cursor=0 apply left, up (no change), then right×5 (stops at 3), then down×5 -> cursor=15. Up+right in the same cycle from 5 -> 1.
- Match: select 0 then 1 (equal faces) -> face_up=16'h0003, pairs_found=1, back in PICK1 one cycle after COMPARE. Selecting 0 again is ignored.
- Mismatch: with MISMATCH_CYCLES=4 select 2 then 4 (faces 1 vs 2) -> busy high 5 cycles. Bits 2 and 4 are set for 4 cycles after COMPARE, then clear. btn_sel during busy is dropped.
- Win: match all 8 pairs -> game_won=1, face_up=16'hFFFF, pairs_found=8. Moves are ignored. start -> face_up=0, game_won=0.
- CARD_MATCH_ATTEMPTS_EN: 300 alternating mismatch attempts -> attempts=255. start -> 0.

Source files
------------

// File: rtl/card_match_pkg.sv
// Shared types and constants for the 4x4 memory-card game sequencer.
// Grid index is row-major: row = idx[3:2], col = idx[1:0].
package card_match_pkg;

  localparam int GRID_DIM       = 4;
  localparam int NUM_CARDS      = GRID_DIM * GRID_DIM;
  localparam int NUM_PAIRS      = NUM_CARDS / 2;
  localparam int FACE_W_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK1,
    ST_PICK2,
    ST_COMPARE,
    ST_SHOW_MISS,
    ST_WON
  } state_t;

  function automatic logic [1:0] idx_row(input logic [3:0] idx);
    return idx[3:2];
  endfunction

  function automatic logic [1:0] idx_col(input logic [3:0] idx);
    return idx[1:0];
  endfunction

endpackage

// File: rtl/card_cursor_nav.sv
// Combinational next-cursor: one move per cycle, priority up > down > left > right,
// clamped at the board edges (no wrap-around).
module card_cursor_nav
  import card_match_pkg::*;
(
  input  logic [3:0] cursor,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [3:0] next_cursor
);

  localparam logic [1:0] EDGE_MAX = 2'(GRID_DIM - 1);

  // The highest-priority pressed button wins even when it is clamped at an edge.
  always_comb begin
    next_cursor = cursor;
    if (up) begin
      if (idx_row(cursor) != 2'd0) next_cursor = cursor - 4'd4;
    end else if (down) begin
      if (idx_row(cursor) != EDGE_MAX) next_cursor = cursor + 4'd4;
    end else if (left) begin
      if (idx_col(cursor) != 2'd0) next_cursor = cursor - 4'd1;
    end else if (right) begin
      if (idx_col(cursor) != EDGE_MAX) next_cursor = cursor + 4'd1;
    end
  end

endmodule

// File: rtl/card_match_ctrl.sv
// Memory-card game sequencer: cursor, face-up mask, pair matching and mismatch hold.
// Optional macro CARD_MATCH_ATTEMPTS_EN adds a saturating attempts[7:0] counter output.
module card_match_ctrl
  import card_match_pkg::*;
#(
  parameter int MISMATCH_CYCLES = 25_000_000,
  parameter int FACE_W          = FACE_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_CARDS*FACE_W-1:0] layout,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        btn_sel,
  output logic [NUM_CARDS-1:0]        face_up,
  output logic [3:0]                  cursor,
  output logic [3:0]                  pairs_found,
  output logic                        game_won,
  output logic                        busy
`ifdef CARD_MATCH_ATTEMPTS_EN
  ,
  output logic [7:0]                  attempts
`endif
);

  localparam int                 TIMER_W    = (MISMATCH_CYCLES > 1) ? $clog2(MISMATCH_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(MISMATCH_CYCLES - 1);
  localparam logic [3:0]         PAIRS_ALL  = 4'(NUM_PAIRS);

  state_t                      state_q, state_d;
  logic [NUM_CARDS*FACE_W-1:0] layout_q, layout_d;
  logic [NUM_CARDS-1:0]        matched_q, matched_d;
  logic [NUM_CARDS-1:0]        face_up_d;
  logic [3:0]                  cursor_d, pairs_d;
  logic [3:0]                  first_q, first_d;
  logic [3:0]                  second_q, second_d;
  logic [TIMER_W-1:0]          timer_q, timer_d;
  logic                        game_won_d, busy_d;
  logic [3:0]                  nav_cursor;
`ifdef CARD_MATCH_ATTEMPTS_EN
  logic [7:0]                  attempts_d;
`endif

  function automatic logic [FACE_W-1:0] face_of(input logic [NUM_CARDS*FACE_W-1:0] lay,
                                                input logic [3:0]                  idx);
    return lay[idx*FACE_W +: FACE_W];
  endfunction

  card_cursor_nav u_nav (
    .cursor      (cursor),
    .up          (btn_up),
    .down        (btn_down),
    .left        (btn_left),
    .right       (btn_right),
    .next_cursor (nav_cursor)
  );

  // NOTE: every signal driven here gets its hold value first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    layout_d   = layout_q;
    matched_d  = matched_q;
    face_up_d  = face_up;
    cursor_d   = cursor;
    pairs_d    = pairs_found;
    first_d    = first_q;
    second_d   = second_q;
    timer_d    = timer_q;
`ifdef CARD_MATCH_ATTEMPTS_EN
    attempts_d = attempts;
`endif

    unique case (state_q)
      ST_PICK1: begin
        // Selection uses the pre-move cursor; a simultaneous move still applies.
        if (btn_sel && !face_up[cursor]) begin
          face_up_d[cursor] = 1'b1;
          first_d           = cursor;
          state_d           = ST_PICK2;
        end
        cursor_d = nav_cursor;
      end
      ST_PICK2: begin
        if (btn_sel && !face_up[cursor]) begin
          face_up_d[cursor] = 1'b1;
          second_d          = cursor;
          state_d           = ST_COMPARE;
        end
        cursor_d = nav_cursor;
      end
      ST_COMPARE: begin
`ifdef CARD_MATCH_ATTEMPTS_EN
        if (attempts != 8'hFF) attempts_d = attempts + 8'd1;
`endif
        if (face_of(layout_q, first_q) == face_of(layout_q, second_q)) begin
          matched_d[first_q]  = 1'b1;
          matched_d[second_q] = 1'b1;
          pairs_d             = pairs_found + 4'd1;
          state_d             = (pairs_d == PAIRS_ALL) ? ST_WON : ST_PICK1;
        end else begin
          timer_d = TIMER_LOAD;
          state_d = ST_SHOW_MISS;
        end
      end
      ST_SHOW_MISS: begin
        // Dropping the two pending picks leaves exactly the matched cards showing.
        if (timer_q == '0) begin
          face_up_d = matched_q;
          state_d   = ST_PICK1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: ;  // ST_IDLE and ST_WON wait for start
    endcase

    if (start) begin
      layout_d   = layout;
      matched_d  = '0;
      face_up_d  = '0;
      pairs_d    = '0;
      cursor_d   = '0;
      state_d    = ST_PICK1;
`ifdef CARD_MATCH_ATTEMPTS_EN
      attempts_d = '0;
`endif
    end

    game_won_d = (state_d == ST_WON);
    busy_d     = (state_d == ST_COMPARE) || (state_d == ST_SHOW_MISS);
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      // NOTE: the layout store is reset as well, so no compare ever sees undefined faces.
      layout_q    <= '0;
      matched_q   <= '0;
      face_up     <= '0;
      cursor      <= '0;
      pairs_found <= '0;
      first_q     <= '0;
      second_q    <= '0;
      timer_q     <= '0;
      game_won    <= 1'b0;
      busy        <= 1'b0;
`ifdef CARD_MATCH_ATTEMPTS_EN
      attempts    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      layout_q    <= layout_d;
      matched_q   <= matched_d;
      face_up     <= face_up_d;
      cursor      <= cursor_d;
      pairs_found <= pairs_d;
      first_q     <= first_d;
      second_q    <= second_d;
      timer_q     <= timer_d;
      game_won    <= game_won_d;
      busy        <= busy_d;
`ifdef CARD_MATCH_ATTEMPTS_EN
      attempts    <= attempts_d;
`endif
    end
  end

endmodule

// File: tb/tb_card_match_ctrl.sv
// Self-checking bench for card_match_ctrl: a pick-list behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_card_match_ctrl;

  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [47:0] layout = '0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic [15:0] face_up;
  logic [3:0]  cursor, pairs_found;
  logic        game_won, busy;
`ifdef CARD_MATCH_ATTEMPTS_EN
  logic [7:0]  attempts;
`endif

  int n_vec = 0;
  int n_err = 0;

  card_match_ctrl #(.MISMATCH_CYCLES(M), .FACE_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .layout      (layout),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_sel     (btn_sel),
    .face_up     (face_up),
    .cursor      (cursor),
    .pairs_found (pairs_found),
    .game_won    (game_won),
    .busy        (busy)
`ifdef CARD_MATCH_ATTEMPTS_EN
    ,
    .attempts    (attempts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase = 0;        // 0 no game, 1 playing, 2 won
  int          m_lay[16];
  int          m_picks[$];
  bit          m_cmp = 0;          // two picks waiting to be compared
  int          m_miss = 0;         // cycles of mismatch display remaining
  logic [15:0] m_matched = '0;
  int          m_row = 0, m_col = 0, m_pairs = 0, m_att = 0;

  function automatic logic [15:0] m_face();
    logic [15:0] f = m_matched;
    foreach (m_picks[i]) f[m_picks[i]] = 1'b1;
    return f;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_picks.delete(); m_cmp = 0; m_miss = 0; m_matched = '0;
    m_row = 0; m_col = 0; m_pairs = 0; m_att = 0;
    for (int i = 0; i < 16; i++) m_lay[i] = 0;
  endtask

  task automatic m_step();
    logic [15:0] shown;
    int cur;
    if (start) begin
      for (int i = 0; i < 16; i++) m_lay[i] = int'(layout[i*3 +: 3]);
      m_matched = '0; m_picks.delete(); m_cmp = 0; m_miss = 0;
      m_row = 0; m_col = 0; m_phase = 1; m_pairs = 0; m_att = 0;
    end else if (m_phase == 1) begin
      if (m_cmp) begin
        m_cmp = 0;
        if (m_att < 255) m_att++;
        if (m_lay[m_picks[0]] == m_lay[m_picks[1]]) begin
          m_matched[m_picks[0]] = 1'b1;
          m_matched[m_picks[1]] = 1'b1;
          m_picks.delete();
          m_pairs++;
          if (m_pairs == 8) m_phase = 2;
        end else begin
          m_miss = M;
        end
      end else if (m_miss > 0) begin
        m_miss--;
        if (m_miss == 0) m_picks.delete();
      end else begin
        cur = m_row * 4 + m_col;
        shown = m_face();
        if (btn_sel && !shown[cur]) begin
          m_picks.push_back(cur);
          if (m_picks.size() == 2) m_cmp = 1;
        end
        if (btn_up)         begin if (m_row > 0) m_row--; end
        else if (btn_down)  begin if (m_row < 3) m_row++; end
        else if (btn_left)  begin if (m_col > 0) m_col--; end
        else if (btn_right) begin if (m_col < 3) m_col++; end
      end
    end
  endtask

  initial m_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  always @(negedge clk) begin
    check("face_up",     int'(face_up),     int'(m_face()));
    check("cursor",      int'(cursor),      m_row * 4 + m_col);
    check("pairs_found", int'(pairs_found), m_pairs);
    check("game_won",    int'(game_won),    (m_phase == 2) ? 1 : 0);
    check("busy",        int'(busy),        (m_cmp || m_miss > 0) ? 1 : 0);
`ifdef CARD_MATCH_ATTEMPTS_EN
    check("attempts",    int'(attempts),    m_att);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r, input logic s);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
    tick();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sel();
    press(0, 0, 0, 0, 1);
  endtask

  task automatic goto_card(input int idx);
    for (int k = 0; k < 8; k++) begin
      if      (m_row > idx / 4) press(1, 0, 0, 0, 0);
      else if (m_row < idx / 4) press(0, 1, 0, 0, 0);
      else if (m_col > idx % 4) press(0, 0, 1, 0, 0);
      else if (m_col < idx % 4) press(0, 0, 0, 1, 0);
      else break;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check("busy_timeout", int'(busy), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) layout[i*3 +: 3] = 3'(i / 2);

    // power-up reset
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    tick();

    // get into a game, then reset mid-cycle
    do_start();
    press(0, 0, 0, 1, 0);
    sel();
    check("pre_reset_face", int'(face_up), 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    check("rst_face_up",  int'(face_up),     0);
    check("rst_cursor",   int'(cursor),      0);
    check("rst_pairs",    int'(pairs_found), 0);
    check("rst_busy",     int'(busy),        0);
    check("rst_game_won", int'(game_won),    0);
    #2 rst_n = 1'b1;
    tick();

    // new game
    do_start();
    check("start_cursor", int'(cursor),  0);
    check("start_face",   int'(face_up), 0);

    // navigation and clamping
    press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    check("nav_clamp_0", int'(cursor), 0);
    for (int i = 0; i < 5; i++) press(0, 0, 0, 1, 0);
    check("nav_right_3", int'(cursor), 3);
    for (int i = 0; i < 5; i++) press(0, 1, 0, 0, 0);
    check("nav_down_15", int'(cursor), 15);
    goto_card(5);
    press(1, 0, 0, 1, 0);
    check("nav_up_right", int'(cursor), 1);

    // matching pair 0/1
    goto_card(0);
    sel();
    goto_card(1);
    sel();
    check("cmp_busy", int'(busy), 1);
    tick();
    check("match_face",  int'(face_up),     16'h0003);
    check("match_pairs", int'(pairs_found), 1);
    check("match_busy",  int'(busy),        0);
    goto_card(0);
    sel();
    check("reselect_ignored", int'(face_up), 16'h0003);

    // mismatch 2 vs 4, with dropped presses while busy
    goto_card(2);
    sel();
    goto_card(4);
    sel();
    n = 0;
    while (busy && n < 20) begin
      check("miss_bits", int'(face_up[2] & face_up[4]), 1);
      if (n == 2) press(0, 0, 1, 0, 1);
      else        tick();
      n++;
    end
    check("miss_busy_len", n, 5);
    check("miss_cleared",  int'(face_up), 16'h0003);
    check("miss_cursor",   int'(cursor),  4);

    // remaining pairs to win
    for (int k = 1; k < 8; k++) begin
      goto_card(2 * k);
      sel();
      goto_card(2 * k + 1);
      sel();
      wait_idle();
    end
    check("won_flag",  int'(game_won),    1);
    check("won_face",  int'(face_up),     16'hFFFF);
    check("won_pairs", int'(pairs_found), 8);
    press(1, 0, 1, 0, 1);
    check("won_cursor_frozen", int'(cursor), 15);
    do_start();
    check("restart_face", int'(face_up),  0);
    check("restart_won",  int'(game_won), 0);

`ifdef CARD_MATCH_ATTEMPTS_EN
    for (int a = 0; a < 300; a++) begin
      goto_card(0);
      sel();
      goto_card(2);
      sel();
      wait_idle();
    end
    check("attempts_sat", int'(attempts), 255);
    do_start();
    check("attempts_clr", int'(attempts), 0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
